uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to our fixed 8N1 receiver.
//  Configurable data width, parity and stop bits; 16x-style oversampling with
//  3-sample majority vote and start-glitch rejection.
//  Ready/valid output with per-word error flags and an overrun pulse.
//  Sits between the board RX pin (e.g. ftdi_txd) and the consumer logic in the chip top.
// PARAMETERS
//  CLK_FREQ    25_000_000  system clock, Hz
//  BAUD_RATE   115_200     line rate, bit/s
//  OVERSAMPLE  16          ticks per bit; even, >=8
//  DATA_BITS   8           5..9, LSB first on the line
//  PARITY      PAR_NONE    uart_pkg::parity_e: PAR_NONE / PAR_EVEN / PAR_ODD
//  STOP_BITS   1           1 or 2
// PORTS
//  clk         in   1          system clock
//  rst         in   1          asynchronous, active-high reset
//  serial      in   1          async RX line, idle high
//  data        out  DATA_BITS  received word; stable while data_valid
//  data_valid  out  1          word held; cleared on data_ready
//  data_ready  in   1          consumer accepts word this cycle
//  frame_err   out  1          sideband to data: a stop bit sampled 0
//  parity_err  out  1          sideband to data: parity mismatch; 0 when PAR_NONE
//  overrun     out  1          1-cycle pulse: finished word dropped, holding reg full
//  brk         out  1          1-cycle pulse: break detected; tied 0 unless macro defined
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; sync flops=1; counters 0.
//  Sync: serial passes a 2-flop synchroniser before any use.
//  Tick: DIV = round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)), minimum 1. Divider free-runs in IDLE.
//  Start: on IDLE falling edge, divider and tick count restart at 0.
//  Voting: each bit value = majority of samples at ticks MID-1, MID, MID+1 (MID=OVERSAMPLE/2).
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  START: vote=1 -> IDLE (glitch rejected, nothing reported).
//  DATA: DATA_BITS bits shifted in LSB-first.
//  PARITY: compares even/odd parity over data bits.
//  STOP: STOP_BITS bits, each checked independently.
//  Completion: word completes at the MID+1 sample of the last stop bit.
//  Next cycle: FSM=IDLE and the result is written.
//  IDLE can catch a start edge in the second half of the stop bit.
//  Write with data_valid=0, or data_valid=1 & data_ready=1 in the same cycle:
//    data/flags loaded, data_valid=1, no overrun.
//  Write with data_valid=1 & data_ready=0: held word kept, overrun=1 for 1 cycle.
//  data_ready while data_valid=1 and no write: data_valid->0 next cycle; data/flags hold.
//  frame_err=1 still delivers the word.
//  Mid-frame reset: immediate IDLE, partial word discarded, no pulses.
//  Latency: data_valid rises 1 clk after the last stop sample (+2 clk sync from the pin).
// CONFIGURATION
//  Macro: UART_RX_BREAK_EN
//  Defined, break condition = all data bits 0, parity bit (if any) 0, first stop bit 0:
//   - brk pulses 1 cycle; no word written; no frame_err; no overrun.
//   - FSM enters BRK_WAIT and stays until the synced line is high, then IDLE.
//  Undefined: same frame is delivered as data=0 with frame_err=1; brk tied 0.
// STRUCTURE
//  Package uart_pkg holds:
//   - parity_e
//   - rx_state_e {IDLE, START, DATA, PARITY, STOP, BRK_WAIT}
//   - function calc_div(clk_freq, baud, os)
//  Sub-module uart_baud_gen(clk, rst, restart, tick): divider only.
//  FSM, voter, shifter and holding register live in uart_rx_cfg.
// TESTING
//  Bench config: CLK_FREQ=32_000_000, BAUD=1_000_000, OS=16 (DIV=2).
//  1) 8N1 byte 0xA5, data_ready=1:
//     one data_valid pulse, data=0xA5, frame_err=0, parity_err=0.
//  2) PARITY=PAR_EVEN, 0x07, parity bit 0 (wrong):
//     data=0x07, parity_err=1. Resend with parity bit 1: parity_err=0.
//  3) data_ready=0, send 0x11 then 0x22 back-to-back:
//     data=0x11 held, overrun pulses once at 0x22 completion.
//     Then data_ready=1: data_valid drops 1 clk later.
//  4) Start-glitch: 4-clk low pulse on serial: no data_valid, FSM back to IDLE.
//     Then 0x3C: data=0x3C.
//  5) DATA_BITS=9, STOP_BITS=2, 0x1FF with second stop bit 0: data=0x1FF, frame_err=1.
//  6) Line low for 20 bit times:
//     with UART_RX_BREAK_EN, brk=1 once, no data_valid; next 0x55 received cleanly.
//     Without it, data=0x00, frame_err=1.
//  7) Also: rst asserted mid-DATA, then 0x5A: no output from the aborted frame, data=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    // Rounded clocks-per-tick, never below 1.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        longint den;
        longint q;
        den = longint'(baud) * longint'(os);
        q   = (longint'(clk_freq) + den / 2) / den;
        if (q < 1) q = 1;
        return int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick divider; restart realigns the tick phase to a start edge.
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !restart && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with majority-vote sampling and a one-word holding register.
// Optional break detection is enabled by defining UART_RX_BREAK_EN.
module uart_rx_cfg
    import uart_pkg::parity_e, uart_pkg::PAR_NONE, uart_pkg::PAR_ODD,
           uart_pkg::rx_state_e, uart_pkg::IDLE, uart_pkg::START, uart_pkg::DATA,
           uart_pkg::STOP, uart_pkg::BRK_WAIT, uart_pkg::calc_div;
#(
    parameter int      CLK_FREQ   = 25_000_000,
    parameter int      BAUD_RATE  = 115_200,
    parameter int      OVERSAMPLE = 16,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 brk
);

    localparam int DIV     = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int MID     = OVERSAMPLE / 2;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam bit HAS_PAR = (PARITY != PAR_NONE);

    rx_state_e state_q, state_d;

    logic                 sync1, sync2, line_q;
    logic                 fall;
    logic                 tick, restart, vote_now, vote;
    logic [TW-1:0]        tick_cnt;
    logic                 smp_a, smp_b;
    logic [3:0]           bit_cnt;
    logic                 last_data, last_stop;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, fe_acc;
    logic                 done, brk_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_q <= 1'b1;
        end else begin
            sync1  <= serial;
            sync2  <= sync1;
            line_q <= sync2;
        end
    end

    // Edge, not level: a line held low after a bad frame must not retrigger.
    assign fall = line_q && !sync2;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (restart) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= (tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + 1'b1;
        end
    end

    // Each bit is resolved at its third sample; the state names the bit awaiting a vote.
    assign vote_now  = tick && (tick_cnt == TW'(MID + 1));
    assign vote      = (smp_a & smp_b) | (smp_a & sync2) | (smp_b & sync2);
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));

`ifdef UART_RX_BREAK_EN
    assign brk_cond = (bit_cnt == 4'd0) && !vote && (shreg == '0) && !par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk <= 1'b0;
        end else begin
            brk <= (state_q == STOP) && vote_now && brk_cond;
        end
    end
`else
    assign brk_cond = 1'b0;
    assign brk      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    restart = 1'b1;
                end
            end
            START: begin
                if (vote_now) state_d = vote ? IDLE : DATA;
            end
            DATA: begin
                if (vote_now && last_data) state_d = HAS_PAR ? uart_pkg::PARITY : STOP;
            end
            uart_pkg::PARITY: begin
                if (vote_now) state_d = STOP;
            end
            STOP: begin
                if (vote_now) begin
                    if (brk_cond) begin
                        state_d = BRK_WAIT;
                    end else if (last_stop) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                if (sync2) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            fe_acc  <= 1'b0;
        end else begin
            if (tick && tick_cnt == TW'(MID - 1)) smp_a <= sync2;
            if (tick && tick_cnt == TW'(MID))     smp_b <= sync2;
            if (vote_now) begin
                case (state_q)
                    START: begin
                        bit_cnt <= '0;
                        par_bit <= 1'b0;
                        fe_acc  <= 1'b0;
                    end
                    DATA: begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
                    end
                    uart_pkg::PARITY: par_bit <= vote;
                    STOP: begin
                        if (!vote) fe_acc <= 1'b1;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!data_valid || data_ready) begin
                    data       <= shreg;
                    frame_err  <= fe_acc || !vote;
                    parity_err <= HAS_PAR && ((^shreg ^ par_bit) != (PARITY == PAR_ODD));
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
